// File: rtl/wb_bram_arbiter.sv
// wb_bram_arbiter: round-robin two-master Wishbone arbiter for a single BRAM slave, with stalled-strobe watchdog
module wb_bram_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, nxt;
  logic last_owner;
  logic [7:0] cnt;
  logic own0, own1, hit;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign gnt_o = {own1, own0};
  assign s_cyc_o = own0 ? m0_cyc_i : own1 & m1_cyc_i;
  assign s_stb_o = own0 ? m0_stb_i : own1 & m1_stb_i;
  assign s_we_o  = own0 ? m0_we_i  : own1 & m1_we_i;
  assign s_sel_o = own0 ? m0_sel_i : own1 ? m1_sel_i : '0;
  assign s_adr_o = own0 ? m0_adr_i : own1 ? m1_adr_i : '0;
  assign s_dat_o = own0 ? m0_dat_i : own1 ? m1_dat_i : '0;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & own0 & m0_stb_i;
  assign m1_ack_o = s_ack_i & own1 & m1_stb_i;
  assign hit = s_stb_o & ~s_ack_i & (cnt == 8'(TIMEOUT));
  assign m0_err_o = hit & own0;
  assign m1_err_o = hit & own1;
  // an owner keeps the bus while it holds cyc; ties go to whoever did not own it last
  always_comb
    nxt = state == OWN0 ? (m0_cyc_i ? OWN0 : m1_cyc_i ? OWN1 : IDLE) :
          state == OWN1 ? (m1_cyc_i ? OWN1 : m0_cyc_i ? OWN0 : IDLE) :
          (m0_cyc_i & m1_cyc_i) ? (last_owner ? OWN0 : OWN1) :
          m0_cyc_i ? OWN0 : m1_cyc_i ? OWN1 : IDLE;
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state <= IDLE;
      last_owner <= 1'b1;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (state != IDLE && nxt != state) last_owner <= own1;
      cnt <= (nxt != state || !s_stb_o || s_ack_i || hit) ? '0 : cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_wb_bram_arbiter.sv
// tb_wb_bram_arbiter: directed and randomized checks of wb_bram_arbiter against a cycle reference model
module tb_wb_bram_arbiter;
  localparam int T = 4;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n;
  logic cyc[2], stb[2], we[2];
  logic [3:0] sel[2];
  logic [31:0] adr[2], dat[2];
  logic [31:0] s_dat;
  logic s_ack;
  logic [31:0] m0_dat, m1_dat, s_adr, s_wdat;
  logic m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
  logic [3:0] s_sel;
  logic [1:0] gnt;
  int checks = 0, fails = 0;
  int own = 0, wd = 0;
  bit last = 1, e_hit;

  wb_bram_arbiter #(.TIMEOUT(T)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_dat_o(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_dat_o(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_dat), .s_ack_i(s_ack), .gnt_o(gnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sample();
    int oi;
    bit en;
    @(negedge clk);
    en = own != 0;
    oi = own == 2 ? 1 : 0;
    e_hit = en && stb[oi] && !s_ack && wd == T;
    chk("gnt", 32'(gnt), own == 1 ? 1 : own == 2 ? 2 : 0);
    chk("s_cyc", 32'(s_cyc), 32'(en && cyc[oi]));
    chk("s_stb", 32'(s_stb), 32'(en && stb[oi]));
    chk("s_we", 32'(s_we), 32'(en && we[oi]));
    chk("s_sel", 32'(s_sel), en ? 32'(sel[oi]) : 0);
    chk("s_adr", s_adr, en ? adr[oi] : 0);
    chk("s_dat", s_wdat, en ? dat[oi] : 0);
    chk("m0_ack", 32'(m0_ack), 32'(own == 1 && s_ack && stb[0]));
    chk("m1_ack", 32'(m1_ack), 32'(own == 2 && s_ack && stb[1]));
    chk("m0_err", 32'(m0_err), 32'(e_hit && own == 1));
    chk("m1_err", 32'(m1_err), 32'(e_hit && own == 2));
    chk("m0_dat", m0_dat, s_dat);
    chk("m1_dat", m1_dat, s_dat);
  endtask

  task automatic advance();
    int oi, nown, nwd;
    bit nlast;
    oi = own == 2 ? 1 : 0;
    nlast = last;
    if (own == 0)
      nown = (cyc[0] && cyc[1]) ? (last ? 1 : 2) : cyc[0] ? 1 : cyc[1] ? 2 : 0;
    else if (cyc[oi])
      nown = own;
    else begin
      nown = cyc[1-oi] ? 2 - oi : 0;
      nlast = oi[0];
    end
    nwd = (nown != own || !(own != 0 && stb[oi]) || s_ack || e_hit) ? 0 : wd + 1;
    @(posedge clk);
    if (!rst_n) begin
      own = 0; last = 1; wd = 0;
    end else begin
      own = nown; last = nlast; wd = nwd;
    end
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic clear();
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; sel[i] = 0; adr[i] = 0; dat[i] = 0;
    end
    s_dat = 0; s_ack = 0;
  endtask

  task automatic do_reset();
    clear();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  initial begin
    int first, ne, beats, ackp;
    bit a0, a1;
    logic [1:0] seen[$];
    clear();
    rst_n = 0;
    @(posedge clk); #1;
    do_reset();
    sample();
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_s_cyc", 32'(s_cyc), 0);
    advance();
    // single read
    cyc[0] = 1; stb[0] = 1; adr[0] = 32'h100; s_dat = 32'hDEADBEEF; s_ack = 1;
    tick();
    sample();
    chk("rd_gnt", 32'(gnt), 1);
    chk("rd_ack", 32'(m0_ack), 1);
    chk("rd_dat", m0_dat, 32'hDEADBEEF);
    chk("rd_m1_ack", 32'(m1_ack), 0);
    advance();
    // tie after reset, then direct handover
    do_reset();
    cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1; s_ack = 1;
    tick();
    sample();
    chk("tie_gnt", 32'(gnt), 1);
    advance();
    cyc[0] = 0; stb[0] = 0;
    tick();
    sample();
    chk("handover_gnt", 32'(gnt), 2);
    advance();
    // round robin single beats
    do_reset();
    cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1; s_ack = 1;
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      sample();
      a0 = m0_ack; a1 = m1_ack;
      if (a0 || a1) begin
        seen.push_back(gnt);
        beats++;
      end
      advance();
      cyc[0] = !a0; stb[0] = !a0; cyc[1] = !a1; stb[1] = !a1;
    end
    chk("rr_beats", beats, 8);
    foreach (seen[i]) chk("rr_order", 32'(seen[i]), i % 2 == 0 ? 1 : 2);
    // write path
    do_reset();
    cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'b0011; adr[1] = 32'h2004; dat[1] = 32'h12345678; s_ack = 1;
    tick();
    sample();
    chk("wr_we", 32'(s_we), 1);
    chk("wr_sel", 32'(s_sel), 4'b0011);
    chk("wr_adr", s_adr, 32'h2004);
    chk("wr_dat", s_wdat, 32'h12345678);
    chk("wr_ack", 32'(m1_ack), 1);
    advance();
    // watchdog
    do_reset();
    cyc[0] = 1; stb[0] = 1; s_ack = 0;
    tick();
    first = 0; ne = 0;
    for (int k = 1; k <= 8; k++) begin
      sample();
      if (m0_err) begin
        ne++;
        if (first == 0) first = k;
      end
      chk("wd_gnt", 32'(gnt), 1);
      advance();
    end
    chk("wd_first", first, 5);
    chk("wd_count", ne, 1);
    // reset mid-burst
    do_reset();
    cyc[1] = 1; stb[1] = 1; s_ack = 1;
    tick();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    cyc[0] = 1; stb[0] = 1;
    sample();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_s_cyc", 32'(s_cyc), 0);
    chk("rst_acks", {m1_ack, m0_ack}, 0);
    advance();
    sample();
    chk("rst_tie_gnt", 32'(gnt), 1);
    advance();
    // randomized traffic
    ackp = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) ackp = $urandom_range(3);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(3) == 0) cyc[i] = !cyc[i];
        stb[i] = cyc[i] & ($urandom_range(3) != 0);
        we[i] = $urandom_range(1);
        sel[i] = 4'($urandom);
        adr[i] = $urandom;
        dat[i] = $urandom;
      end
      s_dat = $urandom;
      s_ack = $urandom_range(2) < ackp;
      rst_n = $urandom_range(63) != 0;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
